// File: rtl/intc_sched_if.sv
// PicoBlaze-side interrupt bus: sources, I/O write port, ack handshake and status.
// master drives the CPU/source side, slave is the interrupt scheduler.
interface intc_sched_if;
  logic [3:0] irq_src;
  logic       write_strobe;
  logic [7:0] port_id;
  logic [7:0] io_data_in;
  logic       interrupt_ack;
  logic       interrupt;
  logic [7:0] irq_status;

  modport master (
    output irq_src, write_strobe, port_id, io_data_in, interrupt_ack,
    input  interrupt, irq_status
  );

  modport slave (
    input  irq_src, write_strobe, port_id, io_data_in, interrupt_ack,
    output interrupt, irq_status
  );
endinterface

// File: rtl/intc_sched.sv
// Four-source rising-edge interrupt scheduler for PicoBlaze with mask, EOI and sticky overflow.
// Optional feature macro INTC_TIMER_EN: source 3 comes from an internal TICK_DIV-cycle tick.
module intc_sched #(
  parameter logic [7:0]  PA_IRQ_MASK = 8'h08,
  parameter logic [7:0]  PA_IRQ_EOI  = 8'h18,
  parameter logic [31:0] TICK_DIV    = 32'd100000
) (
  input logic        sysclk,
  input logic        sysreset,
  intc_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t     state_reg;
  logic [3:0] src_eff;
  logic [3:0] src_q_reg;
  logic [3:0] rise;
  logic [3:0] pending_reg;
  logic [3:0] pending_next;
  logic [3:0] mask_reg;
  logic [3:0] avail;
  logic [3:0] clr;
  logic [1:0] vec_reg;
  logic [1:0] vec_next;
  logic       armed_reg;
  logic       ovf_reg;
  logic       ovf_next;
  logic       int_reg;
  logic       mask_wr;
  logic       eoi;
  logic       unused_bits;

  // A tick period below 2 would hold the tick high permanently and never re-trigger.
  if (TICK_DIV < 32'd2) begin : g_tick_div_check
    $error("intc_sched: TICK_DIV must be at least 2");
  end

`ifdef INTC_TIMER_EN
  logic [31:0] tick_cnt_reg;
  logic        tick_reg;

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      tick_cnt_reg <= 32'd0;
      tick_reg     <= 1'b0;
    end else if (tick_cnt_reg == TICK_DIV - 32'd1) begin
      tick_cnt_reg <= 32'd0;
      tick_reg     <= 1'b1;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 32'd1;
      tick_reg     <= 1'b0;
    end
  end

  assign src_eff     = {tick_reg, bus.irq_src[2:0]};
  assign unused_bits = &{1'b0, bus.io_data_in[7:4], bus.irq_src[3]};
`else
  assign src_eff     = bus.irq_src;
  assign unused_bits = &{1'b0, bus.io_data_in[7:4]};
`endif

  assign mask_wr = bus.write_strobe && (bus.port_id == PA_IRQ_MASK);
  assign eoi     = (state_reg == SERV) && bus.write_strobe && (bus.port_id == PA_IRQ_EOI);

  // armed_reg suppresses edge detection on the first cycle after reset release,
  // so a source already held high is not mistaken for a new rising edge.
  assign rise  = armed_reg ? (src_eff & ~src_q_reg) : 4'b0000;
  assign avail = pending_reg & ~mask_reg;

  // A new rise on the serviced source wins over its EOI clear.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pend
    assign clr[gi]          = eoi && (vec_reg == 2'(gi));
    assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~clr[gi]);
  end

  assign ovf_next = eoi ? 1'b0 : (ovf_reg | (|(rise & pending_reg)));

  always_comb begin
    vec_next = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (avail[i]) vec_next = 2'(i);
    end
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      src_q_reg   <= 4'b0000;
      armed_reg   <= 1'b0;
      pending_reg <= 4'b0000;
      mask_reg    <= 4'b0000;
      ovf_reg     <= 1'b0;
    end else begin
      src_q_reg   <= src_eff;
      armed_reg   <= 1'b1;
      pending_reg <= pending_next;
      ovf_reg     <= ovf_next;
      if (mask_wr) mask_reg <= bus.io_data_in[3:0];
    end
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      state_reg <= IDLE;
      vec_reg   <= 2'd0;
      int_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|avail) begin
            vec_reg   <= vec_next;
            int_reg   <= 1'b1;
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (bus.interrupt_ack) begin
            int_reg   <= 1'b0;
            state_reg <= SERV;
          end
        end
        SERV: begin
          if (eoi) begin
            vec_reg   <= 2'd0;
            state_reg <= IDLE;
          end
        end
        default: begin
          int_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.interrupt  = int_reg;
  assign bus.irq_status = {(state_reg != IDLE), vec_reg, ovf_reg, pending_reg};

endmodule

// File: tb/tb_intc_sched.sv
// Self-checking bench for intc_sched: scoreboard of expected status per interrupt request.
// Build with INTC_TIMER_EN defined to exercise the internal tick source instead.
module tb_intc_sched;

  localparam logic [7:0] PA_MASK = 8'h08;
  localparam logic [7:0] PA_EOI  = 8'h18;
  localparam int         TICK    = 10;

  logic sysclk = 1'b0;
  logic sysreset = 1'b0;
  intc_sched_if bus ();

  intc_sched #(
    .PA_IRQ_MASK(PA_MASK),
    .PA_IRQ_EOI (PA_EOI),
    .TICK_DIV   (32'(TICK))
  ) dut (
    .sysclk  (sysclk),
    .sysreset(sysreset),
    .bus     (bus)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  bit seen;

  function automatic logic [7:0] st(input bit busy, input logic [1:0] v, input bit o, input logic [3:0] p);
    return {busy, v, o, p};
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic pulse_src(input logic [3:0] v);
    bus.irq_src = v;
    tick();
    bus.irq_src = 4'b0000;
  endtask

  task automatic write_port(input logic [7:0] addr, input logic [7:0] data);
    bus.write_strobe = 1'b1;
    bus.port_id      = addr;
    bus.io_data_in   = data;
    tick();
    bus.write_strobe = 1'b0;
    bus.port_id      = 8'h00;
    bus.io_data_in   = 8'h00;
  endtask

  task automatic do_ack();
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
  endtask

  task automatic wait_int(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (bus.interrupt === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    sysreset = 1'b0;
    bus.irq_src = 4'b0000; bus.write_strobe = 1'b0; bus.port_id = 8'h00;
    bus.io_data_in = 8'h00; bus.interrupt_ack = 1'b0;
    tick(); tick();
    checks++; if (bus.interrupt !== 1'b0) $display("FAIL reset_int: got %b want 0", bus.interrupt); else passes++;
    checks++; if (bus.irq_status !== 8'h00) $display("FAIL reset_status: got %h want 00", bus.irq_status); else passes++;
    sysreset = 1'b1;
    tick();
    $display("reset: int=%b status=%h", bus.interrupt, bus.irq_status);
  endtask

  task automatic test_single();
    exp_q.push_back(st(1, 2'd2, 0, 4'b0100));
    pulse_src(4'b0100);
    checks++; if (bus.interrupt !== 1'b0) $display("FAIL single_lat1: got %b want 0", bus.interrupt); else passes++;
    checks++; if (bus.irq_status !== 8'h04) $display("FAIL single_pend: got %h want 04", bus.irq_status); else passes++;
    tick();
    checks++; if (bus.interrupt !== 1'b1) $display("FAIL single_lat2: got %b want 1", bus.interrupt); else passes++;
    exp_v = exp_q.pop_front();
    checks++; if (bus.irq_status !== exp_v) $display("FAIL single_req: got %h want %h", bus.irq_status, exp_v); else passes++;
    do_ack();
    checks++; if (bus.interrupt !== 1'b0) $display("FAIL single_ack: got %b want 0", bus.interrupt); else passes++;
    do_ack();
    checks++; if (bus.irq_status !== exp_v) $display("FAIL single_serv: got %h want %h", bus.irq_status, exp_v); else passes++;
    write_port(PA_EOI, 8'h00);
    checks++; if (bus.irq_status !== 8'h00) $display("FAIL single_eoi: got %h want 00", bus.irq_status); else passes++;
    $display("single: status=%h int=%b", bus.irq_status, bus.interrupt);
  endtask

  task automatic test_priority();
    exp_q.push_back(st(1, 2'd1, 0, 4'b1010));
    exp_q.push_back(st(1, 2'd3, 0, 4'b1000));
    pulse_src(4'b1010);
    for (int k = 0; k < 2; k++) begin
      wait_int(4, seen);
      checks++; if (!seen) $display("FAIL prio_timeout%0d: got no interrupt want 1", k); else passes++;
      exp_v = exp_q.pop_front();
      checks++; if (bus.irq_status !== exp_v) $display("FAIL prio_req%0d: got %h want %h", k, bus.irq_status, exp_v); else passes++;
      $display("priority: req %0d status=%h", k, bus.irq_status);
      do_ack();
      write_port(PA_EOI, 8'h00);
    end
    checks++; if (bus.irq_status !== 8'h00) $display("FAIL prio_done: got %h want 00", bus.irq_status); else passes++;
  endtask

  task automatic test_mask();
    write_port(PA_MASK, 8'h01);
    pulse_src(4'b0001);
    tick(); tick(); tick();
    checks++; if (bus.interrupt !== 1'b0) $display("FAIL mask_block: got %b want 0", bus.interrupt); else passes++;
    checks++; if (bus.irq_status !== 8'h01) $display("FAIL mask_pend: got %h want 01", bus.irq_status); else passes++;
    exp_q.push_back(st(1, 2'd0, 0, 4'b0001));
    write_port(PA_MASK, 8'h00);
    wait_int(2, seen);
    checks++; if (!seen) $display("FAIL mask_release: got no interrupt want 1"); else passes++;
    exp_v = exp_q.pop_front();
    checks++; if (bus.irq_status !== exp_v) $display("FAIL mask_req: got %h want %h", bus.irq_status, exp_v); else passes++;
    $display("mask: status=%h", bus.irq_status);
    do_ack();
    write_port(PA_EOI, 8'h00);
  endtask

  task automatic test_ovf();
    exp_q.push_back(st(1, 2'd2, 0, 4'b0100));
    pulse_src(4'b0100);
    wait_int(4, seen);
    exp_v = exp_q.pop_front();
    checks++; if (bus.irq_status !== exp_v) $display("FAIL ovf_req: got %h want %h", bus.irq_status, exp_v); else passes++;
    do_ack();
    pulse_src(4'b0100);
    tick();
    checks++; if (bus.irq_status !== st(1, 2'd2, 1, 4'b0100)) $display("FAIL ovf_set: got %h want d4", bus.irq_status); else passes++;
    // rise on the serviced source in the same cycle as its EOI
    bus.irq_src = 4'b0100;
    write_port(PA_EOI, 8'h00);
    bus.irq_src = 4'b0000;
    checks++; if (bus.irq_status !== 8'h04) $display("FAIL ovf_eoi_race: got %h want 04", bus.irq_status); else passes++;
    exp_q.push_back(st(1, 2'd2, 0, 4'b0100));
    wait_int(3, seen);
    checks++; if (!seen) $display("FAIL ovf_rereq: got no interrupt want 1"); else passes++;
    exp_v = exp_q.pop_front();
    checks++; if (bus.irq_status !== exp_v) $display("FAIL ovf_rereq_status: got %h want %h", bus.irq_status, exp_v); else passes++;
    $display("ovf: status=%h", bus.irq_status);
    do_ack();
    write_port(PA_EOI, 8'h00);
  endtask

  task automatic test_ignore();
    write_port(PA_MASK, 8'h0F);
    pulse_src(4'b0010);
    do_ack();
    write_port(PA_EOI, 8'h00);
    checks++; if (bus.irq_status !== 8'h02) $display("FAIL ign_idle: got %h want 02", bus.irq_status); else passes++;
    exp_q.push_back(st(1, 2'd1, 0, 4'b0010));
    write_port(PA_MASK, 8'h00);
    wait_int(3, seen);
    exp_v = exp_q.pop_front();
    write_port(PA_EOI, 8'h00);
    write_port(PA_MASK, 8'h0F);
    checks++; if (bus.interrupt !== 1'b1) $display("FAIL ign_eoi_req: got %b want 1", bus.interrupt); else passes++;
    checks++; if (bus.irq_status !== exp_v) $display("FAIL ign_vec_hold: got %h want %h", bus.irq_status, exp_v); else passes++;
    $display("ignore: status=%h", bus.irq_status);
    do_ack();
    write_port(PA_EOI, 8'h00);
    write_port(PA_MASK, 8'h00);
  endtask

  task automatic test_reset_mid();
    bus.irq_src = 4'b0001;
    exp_q.push_back(st(1, 2'd0, 0, 4'b0001));
    wait_int(4, seen);
    exp_v = exp_q.pop_front();
    checks++; if (bus.irq_status !== exp_v) $display("FAIL rmid_req: got %h want %h", bus.irq_status, exp_v); else passes++;
    #2 sysreset = 1'b0;
    #1;
    checks++; if (bus.interrupt !== 1'b0) $display("FAIL rmid_int: got %b want 0", bus.interrupt); else passes++;
    checks++; if (bus.irq_status !== 8'h00) $display("FAIL rmid_status: got %h want 00", bus.irq_status); else passes++;
    tick();
    sysreset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (bus.interrupt !== 1'b0) $display("FAIL rmid_release_int: got %b want 0", bus.interrupt); else passes++;
    checks++; if (bus.irq_status !== 8'h00) $display("FAIL rmid_release_status: got %h want 00", bus.irq_status); else passes++;
    $display("reset_mid: status=%h int=%b", bus.irq_status, bus.interrupt);
    bus.irq_src = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(st(1, 2'd0, 0, 4'b0111));
    exp_q.push_back(st(1, 2'd1, 0, 4'b0110));
    exp_q.push_back(st(1, 2'd2, 0, 4'b0100));
    pulse_src(4'b0111);
    while (exp_q.size() > 0) begin
      wait_int(4, seen);
      checks++; if (!seen) $display("FAIL b2b_timeout: got no interrupt want 1"); else passes++;
      exp_v = exp_q.pop_front();
      checks++; if (bus.irq_status !== exp_v) $display("FAIL b2b_req: got %h want %h", bus.irq_status, exp_v); else passes++;
      $display("back_to_back: status=%h", bus.irq_status);
      do_ack();
      write_port(PA_EOI, 8'h00);
    end
    checks++; if (bus.irq_status !== 8'h00) $display("FAIL b2b_done: got %h want 00", bus.irq_status); else passes++;
  endtask

  task automatic test_timer();
    int first_pend;
    int first_ovf;
    first_pend = 0;
    first_ovf  = 0;
    sysreset = 1'b0;
    tick();
    sysreset = 1'b1;
    for (int c = 1; c <= 4 * TICK; c++) begin
      bus.irq_src[3] = c[0];
      tick();
      if (bus.irq_status[3] === 1'b1 && first_pend == 0) first_pend = c;
      if (bus.irq_status[4] === 1'b1 && first_ovf == 0) first_ovf = c;
    end
    bus.irq_src = 4'b0000;
    checks++; if (first_pend != TICK + 1) $display("FAIL timer_first: got %0d want %0d", first_pend, TICK + 1); else passes++;
    checks++; if (first_ovf != 2 * TICK + 1) $display("FAIL timer_period: got %0d want %0d", first_ovf, 2 * TICK + 1); else passes++;
    $display("timer: first pending at %0d, second tick at %0d", first_pend, first_ovf);
  endtask

  initial begin
    test_reset();
`ifdef INTC_TIMER_EN
    test_timer();
`else
    test_single();
    test_priority();
    test_mask();
    test_ovf();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
